// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and helpers for the ALU execution unit.
// Used by alu_exec_unit and alu_divider (ALU_ITERATIVE_DIV_EN selects the divider).
package alu_pkg;

    localparam logic [4:0] OpAdd  = 5'd1;
    localparam logic [4:0] OpSub  = 5'd2;
    localparam logic [4:0] OpMult = 5'd3;
    localparam logic [4:0] OpDiv  = 5'd4;
    localparam logic [4:0] OpRem  = 5'd5;
    localparam logic [4:0] OpAbs  = 5'd6;
    localparam logic [4:0] OpNot  = 5'd7;
    localparam logic [4:0] OpAnd  = 5'd8;
    localparam logic [4:0] OpNand = 5'd9;
    localparam logic [4:0] OpOr   = 5'd10;
    localparam logic [4:0] OpNor  = 5'd11;
    localparam logic [4:0] OpXor  = 5'd12;
    localparam logic [4:0] OpXnor = 5'd13;
    localparam logic [4:0] OpSet  = 5'd16;
    localparam logic [4:0] OpSlt  = 5'd17;
    localparam logic [4:0] OpSgt  = 5'd18;
    localparam logic [4:0] OpSdt  = 5'd19;
    localparam logic [4:0] OpSlet = 5'd21;
    localparam logic [4:0] OpSget = 5'd22;

    localparam int unsigned DIV_CYCLES = 32;

    typedef enum logic {StIdle, StDivide} alu_state_e;

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == OpDiv) || (op == OpRem);
    endfunction

    function automatic logic is_supported(input logic [4:0] op);
        logic ok;
        case (op)
            OpAdd, OpSub, OpMult, OpDiv, OpRem, OpAbs, OpNot, OpAnd, OpNand, OpOr, OpNor,
            OpXor, OpXnor, OpSet, OpSlt, OpSgt, OpSdt, OpSlet, OpSget: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Single-cycle ops only; DIV/REM and unsupported codes yield 0 here.
    function automatic logic [31:0] alu_calc(input logic [4:0] op, input logic [31:0] v1,
                                             input logic [31:0] v2);
        logic [31:0] r;
        r = '0;
        case (op)
            OpAdd:  r = v1 + v2;
            OpSub:  r = v1 - v2;
            OpMult: r = v1 * v2;
            OpAbs:  r = v1[31] ? -v1 : v1;
            OpNot:  r = ~v1;
            OpAnd:  r = v1 & v2;
            OpNand: r = ~(v1 & v2);
            OpOr:   r = v1 | v2;
            OpNor:  r = ~(v1 | v2);
            OpXor:  r = v1 ^ v2;
            OpXnor: r = ~(v1 ^ v2);
            OpSet:  r = v2;
            OpSlt:  r = {31'b0, $signed(v1) < $signed(v2)};
            OpSgt:  r = {31'b0, $signed(v1) > $signed(v2)};
            OpSdt:  r = {31'b0, v1 != v2};
            OpSlet: r = {31'b0, $signed(v1) <= $signed(v2)};
            OpSget: r = {31'b0, $signed(v1) >= $signed(v2)};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Decoder-side request and result/write-back bundle of the ALU execution unit.
interface alu_exec_unit_if;

    logic               ALU_start;
    logic [4:0]         ALU_op;
    logic signed [31:0] ALU_v1;
    logic signed [31:0] ALU_v2;
    logic               ALU_write_back_flag;
    logic [7:0]         ALU_write_back_code;
    logic               ALU_busy;
    logic               ALU_done;
    logic [31:0]        ALU_result;
    logic               WB_enable;
    logic [7:0]         WB_code;
    logic               ALU_div_by_zero;

    modport master (
        output ALU_start, ALU_op, ALU_v1, ALU_v2, ALU_write_back_flag, ALU_write_back_code,
        input  ALU_busy, ALU_done, ALU_result, WB_enable, WB_code, ALU_div_by_zero
    );

    modport slave (
        input  ALU_start, ALU_op, ALU_v1, ALU_v2, ALU_write_back_flag, ALU_write_back_code,
        output ALU_busy, ALU_done, ALU_result, WB_enable, WB_code, ALU_div_by_zero
    );

endinterface

// File: rtl/alu_divider.sv
// 32-iteration restoring divider on magnitudes with sign correction of quotient/remainder.
// Instantiated by alu_exec_unit only when ALU_ITERATIVE_DIV_EN is defined.
module alu_divider
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        step_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        last_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d;
    logic        qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] rem_shift, diff;
    logic        fits;
    logic [31:0] rem_step, quo_step;

    always_comb begin
        rem_shift = {rem_q, quo_q[31]};
        diff      = rem_shift - {1'b0, dvs_q};
        fits      = ~diff[32];
        rem_step  = fits ? diff[31:0] : rem_shift[31:0];
        quo_step  = {quo_q[30:0], fits};

        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        dvd_d  = dvd_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        zero_d = zero_q;
        cnt_d  = cnt_q;
        if (start_i) begin
            rem_d  = '0;
            quo_d  = dividend_i[31] ? -dividend_i : dividend_i;
            dvs_d  = divisor_i[31] ? -divisor_i : divisor_i;
            dvd_d  = dividend_i;
            qneg_d = dividend_i[31] ^ divisor_i[31];
            rneg_d = dividend_i[31];
            zero_d = (divisor_i == '0);
            cnt_d  = '0;
        end else if (step_i) begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            dvd_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            zero_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            dvd_q  <= dvd_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            zero_q <= zero_d;
            cnt_q  <= cnt_d;
        end
    end

    // Results reflect the iteration being performed this cycle, valid when last_o is high.
    assign last_o      = (cnt_q == 5'(DIV_CYCLES - 1));
    assign quotient_o  = zero_q ? 32'hFFFF_FFFF : (qneg_q ? -quo_step : quo_step);
    assign remainder_o = zero_q ? dvd_q : (rneg_q ? -rem_step : rem_step);

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle ops, DIV/REM either combinational or, with
// ALU_ITERATIVE_DIV_EN defined, through the multi-cycle alu_divider.
module alu_exec_unit
    import alu_pkg::*;
(
    input logic            clk,
    input logic            reset,
    alu_exec_unit_if.slave bus
);

    alu_state_e  state_q, state_d;
    logic [4:0]  op_q, op_d;
    logic        flag_q, flag_d;
    logic [7:0]  code_q, code_d;
    logic        v2z_q, v2z_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic        accept;

`ifdef ALU_ITERATIVE_DIV_EN
    logic        div_start, div_step, div_last;
    logic [31:0] div_quo, div_rem;

    assign div_start = accept && is_div_op(bus.ALU_op);
    assign div_step  = (state_q == StDivide);

    alu_divider u_divider (
        .clk         (clk),
        .reset       (reset),
        .start_i     (div_start),
        .step_i      (div_step),
        .dividend_i  (bus.ALU_v1),
        .divisor_i   (bus.ALU_v2),
        .last_o      (div_last),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );
`else
    logic [31:0] comb_quo, comb_rem;

    // Zero divisor and the single overflowing quotient are fixed by definition, not by '/'.
    always_comb begin
        comb_quo = '0;
        comb_rem = '0;
        if (bus.ALU_v2 == '0) begin
            comb_quo = 32'hFFFF_FFFF;
            comb_rem = bus.ALU_v1;
        end else if (bus.ALU_v1 == 32'sh8000_0000 && bus.ALU_v2 == -32'sd1) begin
            comb_quo = 32'h8000_0000;
            comb_rem = '0;
        end else begin
            comb_quo = bus.ALU_v1 / bus.ALU_v2;
            comb_rem = bus.ALU_v1 % bus.ALU_v2;
        end
    end
`endif

    assign accept = bus.ALU_start && (state_q == StIdle);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        flag_d   = flag_q;
        code_d   = code_q;
        v2z_d    = v2z_q;
        done_d   = 1'b0;
        result_d = result_q;
        if (accept) begin
            op_d   = bus.ALU_op;
            flag_d = bus.ALU_write_back_flag;
            code_d = bus.ALU_write_back_code;
            v2z_d  = (bus.ALU_v2 == '0);
`ifdef ALU_ITERATIVE_DIV_EN
            if (is_div_op(bus.ALU_op)) begin
                state_d = StDivide;
            end else begin
                done_d   = 1'b1;
                result_d = alu_calc(bus.ALU_op, bus.ALU_v1, bus.ALU_v2);
            end
`else
            done_d = 1'b1;
            if (bus.ALU_op == OpDiv) begin
                result_d = comb_quo;
            end else if (bus.ALU_op == OpRem) begin
                result_d = comb_rem;
            end else begin
                result_d = alu_calc(bus.ALU_op, bus.ALU_v1, bus.ALU_v2);
            end
`endif
        end
`ifdef ALU_ITERATIVE_DIV_EN
        if (state_q == StDivide && div_last) begin
            state_d  = StIdle;
            done_d   = 1'b1;
            result_d = (op_q == OpRem) ? div_rem : div_quo;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            flag_q   <= 1'b0;
            code_q   <= '0;
            v2z_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            flag_q   <= flag_d;
            code_q   <= code_d;
            v2z_q    <= v2z_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.ALU_busy        = (state_q == StDivide);
    assign bus.ALU_done        = done_q;
    assign bus.ALU_result      = result_q;
    assign bus.WB_enable       = done_q && flag_q && is_supported(op_q);
    assign bus.WB_code         = code_q;
    assign bus.ALU_div_by_zero = done_q && is_div_op(op_q) && v2z_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit; expectations adapt to ALU_ITERATIVE_DIV_EN.
module tb_alu_exec_unit;
    import alu_pkg::*;

`ifdef ALU_ITERATIVE_DIV_EN
    localparam int   DivLat  = 33;
    localparam logic DivBusy = 1'b1;
`else
    localparam int   DivLat  = 1;
    localparam logic DivBusy = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] exp;
    } vec_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] exp;
        logic        dbz;
    } dvec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_exec_unit_if bus ();

    alu_exec_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    vec_t arith [22] = '{
        '{OpSub,  32'd5,          32'd7,          32'hFFFF_FFFE},
        '{OpMult, 32'hFFFF_FFFD,  32'd7,          32'hFFFF_FFEB},
        '{OpMult, 32'h7FFF_FFFF,  32'd2,          32'hFFFF_FFFE},
        '{OpAbs,  32'h8000_0000,  32'd0,          32'h8000_0000},
        '{OpAbs,  32'hFFFF_FFFB,  32'd0,          32'h0000_0005},
        '{OpNot,  32'h0F0F_0F0F,  32'd0,          32'hF0F0_F0F0},
        '{OpAnd,  32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0F00_0F00},
        '{OpNand, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'hF0FF_F0FF},
        '{OpOr,   32'hFF00_FF00,  32'h0F0F_0F0F,  32'hFF0F_FF0F},
        '{OpNor,  32'hFF00_FF00,  32'h0F0F_0F0F,  32'h00F0_00F0},
        '{OpXor,  32'hFF00_FF00,  32'h0F0F_0F0F,  32'hF00F_F00F},
        '{OpXnor, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0FF0_0FF0},
        '{OpSet,  32'd0,          32'h1234_5678,  32'h1234_5678},
        '{OpSlt,  32'hFFFF_FFFF,  32'd1,          32'd1},
        '{OpSgt,  32'hFFFF_FFFF,  32'd1,          32'd0},
        '{OpSdt,  32'd3,          32'd4,          32'd1},
        '{OpSdt,  32'd3,          32'd3,          32'd0},
        '{OpSlet, 32'd3,          32'd3,          32'd1},
        '{OpSlet, 32'd4,          32'd3,          32'd0},
        '{OpSget, 32'd3,          32'd3,          32'd1},
        '{OpSget, 32'd2,          32'd3,          32'd0},
        '{OpSub,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF}
    };

    dvec_t divs [10] = '{
        '{OpDiv, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0},
        '{OpRem, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0},
        '{OpDiv, 32'd9,         32'd0,         32'hFFFF_FFFF, 1'b1},
        '{OpRem, 32'd9,         32'd0,         32'd9,         1'b1},
        '{OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0},
        '{OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0},
        '{OpDiv, 32'd100,       32'd7,         32'd14,        1'b0},
        '{OpRem, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0},
        '{OpDiv, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0},
        '{OpRem, 32'd100,       32'hFFFF_FFF9, 32'd2,         1'b0}
    };

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                         input logic flag, input logic [7:0] code);
        bus.ALU_start           = 1'b1;
        bus.ALU_op              = op;
        bus.ALU_v1              = v1;
        bus.ALU_v2              = v2;
        bus.ALU_write_back_flag = flag;
        bus.ALU_write_back_code = code;
    endtask

    // Start in cycle 0; returns in cycle 1 with start released.
    task automatic issue(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                         input logic flag, input logic [7:0] code);
        drive(op, v1, v2, flag, code);
        tick();
        bus.ALU_start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (bus.ALU_done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n_done;
        logic [31:0] last;

        reset = 1'b1;
        bus.ALU_start = 1'b0;
        bus.ALU_op = '0;
        bus.ALU_v1 = '0;
        bus.ALU_v2 = '0;
        bus.ALU_write_back_flag = 1'b0;
        bus.ALU_write_back_code = '0;
        tick();
        tick();
        chk("rst_busy", 32'(bus.ALU_busy), 32'd0);
        chk("rst_done", 32'(bus.ALU_done), 32'd0);
        chk("rst_result", bus.ALU_result, 32'd0);
        chk("rst_wb_en", 32'(bus.WB_enable), 32'd0);
        chk("rst_wb_code", 32'(bus.WB_code), 32'd0);
        chk("rst_dbz", 32'(bus.ALU_div_by_zero), 32'd0);
        reset = 1'b0;
        tick();

        issue(OpAdd, 32'h7FFF_FFFF, 32'd1, 1'b1, 8'd5);
        chk("add_done", 32'(bus.ALU_done), 32'd1);
        chk("add_result", bus.ALU_result, 32'h8000_0000);
        chk("add_wb_en", 32'(bus.WB_enable), 32'd1);
        chk("add_wb_code", 32'(bus.WB_code), 32'd5);
        chk("add_dbz", 32'(bus.ALU_div_by_zero), 32'd0);
        tick();
        chk("pulse_done", 32'(bus.ALU_done), 32'd0);
        chk("hold_result", bus.ALU_result, 32'h8000_0000);
        chk("pulse_wb_en", 32'(bus.WB_enable), 32'd0);

        for (int i = 0; i < 22; i++) begin
            issue(arith[i].op, arith[i].v1, arith[i].v2, 1'b1, 8'(i + 16));
            chk($sformatf("op%0d_done_%0d", arith[i].op, i), 32'(bus.ALU_done), 32'd1);
            chk($sformatf("op%0d_result_%0d", arith[i].op, i), bus.ALU_result, arith[i].exp);
            chk($sformatf("op%0d_wb_en_%0d", arith[i].op, i), 32'(bus.WB_enable), 32'd1);
            chk($sformatf("op%0d_wb_code_%0d", arith[i].op, i), 32'(bus.WB_code), 32'(i + 16));
        end

        issue(OpAdd, 32'd1, 32'd2, 1'b0, 8'd9);
        chk("noflag_result", bus.ALU_result, 32'd3);
        chk("noflag_wb_en", 32'(bus.WB_enable), 32'd0);

        issue(5'h1F, 32'd5, 32'd6, 1'b1, 8'd7);
        chk("unsup_done", 32'(bus.ALU_done), 32'd1);
        chk("unsup_result", bus.ALU_result, 32'd0);
        chk("unsup_wb_en", 32'(bus.WB_enable), 32'd0);

        for (int i = 0; i < 10; i++) begin
            issue(divs[i].op, divs[i].v1, divs[i].v2, 1'b1, 8'(i + 64));
            chk($sformatf("div%0d_busy", i), 32'(bus.ALU_busy), 32'(DivBusy));
            wait_done(lat);
            chk($sformatf("div%0d_latency", i), 32'(lat), 32'(DivLat));
            chk($sformatf("div%0d_result", i), bus.ALU_result, divs[i].exp);
            chk($sformatf("div%0d_dbz", i), 32'(bus.ALU_div_by_zero), 32'(divs[i].dbz));
            chk($sformatf("div%0d_wb_en", i), 32'(bus.WB_enable), 32'd1);
            chk($sformatf("div%0d_wb_code", i), 32'(bus.WB_code), 32'(i + 64));
        end
        tick();

        // Start while busy: ignored when the divider is iterative, accepted otherwise.
        issue(OpDiv, 32'd100, 32'd7, 1'b1, 8'd1);
        n_done = 0;
        last = '0;
        if (bus.ALU_done === 1'b1) begin
            n_done++;
            last = bus.ALU_result;
        end
        drive(OpAdd, 32'd1, 32'd1, 1'b1, 8'd2);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 0) bus.ALU_start = 1'b0;
            if (bus.ALU_done === 1'b1) begin
                n_done++;
                last = bus.ALU_result;
            end
        end
`ifdef ALU_ITERATIVE_DIV_EN
        chk("busy_ign_dones", 32'(n_done), 32'd1);
        chk("busy_ign_result", last, 32'd14);
`else
        chk("busy_ign_dones", 32'(n_done), 32'd2);
        chk("busy_ign_result", last, 32'd2);
`endif

        issue(OpDiv, 32'd100, 32'd7, 1'b1, 8'd1);
        wait_done(lat);
        chk("b2b_div_result", bus.ALU_result, 32'd14);
        issue(OpAdd, 32'd5, 32'd6, 1'b1, 8'd3);
        chk("b2b_add_done", 32'(bus.ALU_done), 32'd1);
        chk("b2b_add_result", bus.ALU_result, 32'd11);
        chk("b2b_add_wb_code", 32'(bus.WB_code), 32'd3);
        tick();

        // Reset asserted in cycle 10 of a divide.
        issue(OpDiv, 32'd100, 32'd7, 1'b1, 8'h55);
        repeat (9) tick();
        chk("abort_busy_before", 32'(bus.ALU_busy), 32'(DivBusy));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(bus.ALU_busy), 32'd0);
        chk("abort_done", 32'(bus.ALU_done), 32'd0);
        chk("abort_result", bus.ALU_result, 32'd0);
        chk("abort_wb_en", 32'(bus.WB_enable), 32'd0);
        chk("abort_wb_code", 32'(bus.WB_code), 32'd0);
        chk("abort_dbz", 32'(bus.ALU_div_by_zero), 32'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.ALU_done === 1'b1) n_done++;
        end
        chk("abort_no_done", 32'(n_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
